dist32_1_8: RTL and testbench
=============================

# dist32_1_8

Write-side counterpart of the datapath's 8:1 32-bit selector: accepts one 32-bit word per handshake and stores it into one of eight output registers. The destination comes from an explicit 3-bit select or from an internal round-robin pointer. Each channel has a full flag, cleared by its consumer's acknowledge. Registered outputs Data0..Data7 feed the downstream selector and consumers directly.

## Interface
- WIDTH, 32, data word width
- N_CH, 8, number of channels (fixed at 8; SEL_W = 3)
- clk  in  1  rising-edge clock, single domain
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  producer offers in_data
- in_ready  out  1  block can accept into the current destination
- in_data  in  WIDTH  word to store
- in_sel  in  3  explicit destination channel, used when auto = 0
- auto  in  1  1 = destination is internal pointer ptr; in_sel ignored
- flush  in  1  synchronous clear of all full flags and ptr
- ch_ack  in  N_CH  per-channel consumer acknowledge, clears that channel's full flag
- Data0..Data7  out  WIDTH each  channel registers
- ch_valid  out  N_CH  per-channel full flag
- ptr  out  3  current round-robin pointer

## Operation
- dest = auto ? ptr : in_sel.
- in_ready = ~flush & (~ch_valid[dest] | ch_ack[dest]). Combinational from dest, ch_valid, ch_ack, flush; no dependence on in_valid.
- Accept when in_valid & in_ready. On the next edge:
  - Data[dest] <= in_data
  - ch_valid[dest] <= 1
  - if auto, ptr <= ptr + 1, modulo 8 (7 -> 0)
- In explicit mode (auto = 0), ptr holds.
- ch_ack[i] with ch_valid[i] = 1 clears ch_valid[i] on the next edge. ch_ack[i] on an empty channel is ignored.
- Ack and write to the same channel in the same cycle: ch_valid stays 1 and Data takes the new word (pass-through refill).
- Ack on channel i while writing channel j != i: both take effect.
- flush = 1 on an edge: ch_valid <= 0 and ptr <= 0, overriding any write and ack in that cycle. Data registers keep their contents.
- Non-destination Data registers never change.
- Mode changes (auto toggling) are legal on any cycle. The new dest applies combinationally in that same cycle.

## Timing
- Reset (async assert): Data0..Data7 = 0, ch_valid = 8'h00, ptr = 3'd0.
  - in_ready during reset is don't-care.
  - After deassert, in_ready = 1 (all channels empty), unless flush is high.
- Latency: an accept in cycle N makes Data[dest] and ch_valid[dest] visible after edge N+1. An ack in cycle N drops ch_valid after edge N+1.
- Throughput: one word per cycle while dest is empty or being acked.
- Backpressure: with dest full and unacked, in_ready = 0. The producer must hold in_data, in_sel and auto stable while in_valid = 1 and in_ready = 0.
- In auto mode, ptr stalls on a full channel. It does not skip ahead to an empty one.
- Reset mid-operation discards all stored words and flags immediately, without waiting for an edge.
- No output depends combinationally on in_data.

## Structure
- Shared package holds the WIDTH, N_CH and SEL_W constants and the channel index type (3-bit).
- Sub-module dec3_8: 3-bit select to 8-bit one-hot decoder.
  - Used to generate the per-channel write enables (one-hot(dest) & accept) and the ack/write combine per channel.
- Top level holds the eight data registers, the full-flag vector and the ptr counter.

## Test plan
- Reset: assert rst mid-cycle with channels 2 and 5 full -> all Data = 0, ch_valid = 0, ptr = 0 immediately. in_ready = 1 after deassert.
- Explicit write: auto = 0, in_sel = 3, in_data = 32'hDEADBEEF, one-cycle handshake -> Data3 = DEADBEEF and ch_valid = 8'h08 next cycle. A second write to sel 3 sees in_ready = 0 until ch_ack[3] is pulsed.
- Auto round-robin: auto = 1, 9 back-to-back writes of 1..9 with acks returned each cycle -> Data0..Data7 = 1..8, then Data0 = 9. ptr goes 0,1,...,7,0,1 (wrap).
- Stall in auto mode: channel 4 full and unacked, ptr = 4 -> in_ready = 0 and ptr holds at 4. Pulse ch_ack[4] with in_valid = 1 -> Data4 updates, ch_valid[4] stays 1, ptr = 5.
- Simultaneous events: write to ch 1 and ack ch 6 in the same cycle -> ch_valid[1] set and ch_valid[6] cleared on one edge. Ack on an empty channel 0 -> no change.
- Flush: flush = 1 together with in_valid to ch 2 -> in_ready = 0, ch_valid = 0, ptr = 0. Data registers unchanged and Data2 not written.

Source files
------------

// File: rtl/dist32_1_8_pkg.sv
// Shared constants and types for the 1:8 32-bit write distributor.
package dist32_1_8_pkg;
   localparam int WIDTH = 32;
   localparam int N_CH  = 8;
   localparam int SEL_W = 3;

   typedef logic [SEL_W-1:0] ch_idx_t;
endpackage

// File: rtl/dist32_1_8_dec3_8.sv
// 3-bit select to 8-bit one-hot decoder.
module dec3_8
   import dist32_1_8_pkg::*;
(
   input  ch_idx_t          i_sel,
   output logic [N_CH-1:0]  o_onehot
);
   always_comb begin
      o_onehot        = '0;
      o_onehot[i_sel] = 1'b1;
   end
endmodule

// File: rtl/dist32_1_8.sv
// Write-side distributor: one word per handshake into one of eight channel registers,
// destination chosen by explicit select or a round-robin pointer that stalls on a full channel.
module dist32_1_8
   import dist32_1_8_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   input  ch_idx_t           in_sel,
   input  logic              auto,
   input  logic              flush,
   input  logic [N_CH-1:0]   ch_ack,
   output logic [WIDTH-1:0]  Data0,
   output logic [WIDTH-1:0]  Data1,
   output logic [WIDTH-1:0]  Data2,
   output logic [WIDTH-1:0]  Data3,
   output logic [WIDTH-1:0]  Data4,
   output logic [WIDTH-1:0]  Data5,
   output logic [WIDTH-1:0]  Data6,
   output logic [WIDTH-1:0]  Data7,
   output logic [N_CH-1:0]   ch_valid,
   output ch_idx_t           ptr
);
   logic [WIDTH-1:0] r_data [N_CH];
   logic [N_CH-1:0]  r_valid;
   ch_idx_t          r_ptr;

   ch_idx_t          w_dest;
   logic [N_CH-1:0]  w_dest_oh;
   logic [N_CH-1:0]  w_wr_en;
   logic             w_accept;

   assign w_dest   = auto ? r_ptr : in_sel;
   assign in_ready = ~flush & (~r_valid[w_dest] | ch_ack[w_dest]);
   assign w_accept = in_valid & in_ready;

   dec3_8 u_dec (
      .i_sel    (w_dest),
      .o_onehot (w_dest_oh)
   );

   assign w_wr_en = w_dest_oh & {N_CH{w_accept}};

   // NOTE: the data registers are reset because a reset must visibly clear every channel word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_CH; i++) r_data[i] <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++)
            if (w_wr_en[i]) r_data[i] <= in_data;
      end
   end

   // A write wins over an ack on the same channel, so a refill keeps the flag set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
         r_ptr   <= '0;
      end else if (flush) begin
         r_valid <= '0;
         r_ptr   <= '0;
      end else begin
         r_valid <= (r_valid & ~ch_ack) | w_wr_en;
         if (w_accept && auto) r_ptr <= r_ptr + 3'd1;
      end
   end

   assign Data0    = r_data[0];
   assign Data1    = r_data[1];
   assign Data2    = r_data[2];
   assign Data3    = r_data[3];
   assign Data4    = r_data[4];
   assign Data5    = r_data[5];
   assign Data6    = r_data[6];
   assign Data7    = r_data[7];
   assign ch_valid = r_valid;
   assign ptr      = r_ptr;
endmodule

// File: tb/tb_dist32_1_8.sv
// Scoreboard bench for dist32_1_8: driver pushes expected post-edge state, monitor pops and compares.
module tb_dist32_1_8;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic [2:0]  in_sel = '0;
   logic        auto = 1'b0;
   logic        flush = 1'b0;
   logic [7:0]  ch_ack = '0;
   logic [31:0] Data0, Data1, Data2, Data3, Data4, Data5, Data6, Data7;
   logic [7:0]  ch_valid;
   logic [2:0]  ptr;

   dist32_1_8 dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_sel(in_sel), .auto(auto), .flush(flush),
      .ch_ack(ch_ack), .Data0(Data0), .Data1(Data1), .Data2(Data2),
      .Data3(Data3), .Data4(Data4), .Data5(Data5), .Data6(Data6),
      .Data7(Data7), .ch_valid(ch_valid), .ptr(ptr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0][31:0] d;
      logic [7:0]       v;
      logic [2:0]       p;
      string            nm;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_errors = 0;

   // Reference model state
   logic [31:0] m_d [8];
   logic [7:0]  m_v;
   int          m_ptr;

   logic [7:0][31:0] w_dut_d;
   assign w_dut_d = {Data7, Data6, Data5, Data4, Data3, Data2, Data1, Data0};

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_d[i] = '0;
      m_v   = '0;
      m_ptr = 0;
   endtask

   task automatic push_exp(input string nm);
      exp_t e;
      for (int i = 0; i < 8; i++) e.d[i] = m_d[i];
      e.v  = m_v;
      e.p  = 3'(m_ptr);
      e.nm = nm;
      sb_q.push_back(e);
   endtask

   // One clock of stimulus: drive, check in_ready, advance the model, queue expected state.
   task automatic cycle(input logic v, input logic [31:0] d, input logic [2:0] s,
                        input logic a, input logic f, input logic [7:0] ack,
                        input string nm, output logic rdy);
      int  dest;
      logic exp_rdy;
      @(negedge clk);
      #1;
      in_valid = v; in_data = d; in_sel = s; auto = a; flush = f; ch_ack = ack;
      #1;
      dest    = a ? m_ptr : int'(s);
      exp_rdy = !f && (!m_v[dest] || ack[dest]);
      check({nm, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
      rdy = exp_rdy;
      if (f) begin
         m_v   = '0;
         m_ptr = 0;
      end else begin
         m_v = m_v & ~ack;
         if (v && exp_rdy) begin
            m_d[dest] = d;
            m_v[dest] = 1'b1;
            if (a) m_ptr = (m_ptr + 1) % 8;
         end
      end
      push_exp(nm);
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; flush = 1'b0; ch_ack = '0;
   endtask

   task automatic check_reset_state(input string nm);
      for (int i = 0; i < 8; i++) check($sformatf("%s.Data%0d", nm, i), 64'(w_dut_d[i]), 64'd0);
      check({nm, ".ch_valid"}, 64'(ch_valid), 64'd0);
      check({nm, ".ptr"}, 64'(ptr), 64'd0);
   endtask

   // Monitor: every cycle that has a queued expectation, compare the registered outputs.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         for (int i = 0; i < 8; i++)
            check($sformatf("%s.Data%0d", e.nm, i), 64'(w_dut_d[i]), 64'(e.d[i]));
         check({e.nm, ".ch_valid"}, 64'(ch_valid), 64'(e.v));
         check({e.nm, ".ptr"}, 64'(ptr), 64'(e.p));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        rdy;
      logic        hold;
      logic [31:0] hd;
      logic [2:0]  hs;
      logic        ha;

      model_reset();
      #1;
      check_reset_state("por");
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("por.in_ready", 64'(in_ready), 64'd1);

      // Explicit write, then backpressure on the full channel until acked
      cycle(1, 32'hDEADBEEF, 3, 0, 0, 8'h00, "expl_wr", rdy);
      cycle(1, 32'h12345678, 3, 0, 0, 8'h00, "expl_bp0", rdy);
      cycle(1, 32'h12345678, 3, 0, 0, 8'h00, "expl_bp1", rdy);
      cycle(1, 32'h12345678, 3, 0, 0, 8'h08, "expl_ackwr", rdy);

      // Auto round-robin with acks every cycle, wrapping past 7
      cycle(0, 0, 0, 0, 1, 8'h00, "rr_flush", rdy);
      for (int k = 1; k <= 9; k++)
         cycle(1, 32'(k), 0, 1, 0, 8'hFF, $sformatf("rr%0d", k), rdy);

      // Stall: channel 4 full, ptr at 4
      cycle(0, 0, 0, 0, 1, 8'h00, "st_flush", rdy);
      cycle(1, 32'hA4A4A4A4, 4, 0, 0, 8'h00, "st_fill4", rdy);
      for (int k = 0; k < 4; k++)
         cycle(1, 32'h100 + 32'(k), 0, 1, 0, 8'h00, $sformatf("st_auto%0d", k), rdy);
      cycle(1, 32'hCAFEF00D, 0, 1, 0, 8'h00, "st_stall0", rdy);
      cycle(1, 32'hCAFEF00D, 0, 1, 0, 8'h00, "st_stall1", rdy);
      cycle(1, 32'hCAFEF00D, 0, 1, 0, 8'h10, "st_ackwr", rdy);

      // Simultaneous write ch1 / ack ch6, and ack on an empty channel
      cycle(1, 32'h66666666, 6, 0, 0, 8'h00, "sim_fill6", rdy);
      cycle(0, 0, 0, 0, 0, 8'h02, "sim_ack1", rdy);
      cycle(1, 32'h11111111, 1, 0, 0, 8'h40, "sim_wr1ack6", rdy);
      cycle(0, 0, 0, 0, 0, 8'h01, "sim_ack0", rdy);
      cycle(0, 0, 0, 0, 0, 8'h01, "sim_ack0_empty", rdy);

      // Flush overrides a concurrent write
      cycle(1, 32'hBADBAD00, 2, 0, 1, 8'h00, "flush_wr", rdy);
      cycle(0, 0, 0, 0, 0, 8'h00, "flush_after", rdy);

      // Mid-cycle async reset with channels 2 and 5 full
      cycle(1, 32'h22222222, 2, 0, 0, 8'h00, "rst_fill2", rdy);
      cycle(1, 32'h55555555, 5, 0, 0, 8'h00, "rst_fill5", rdy);
      @(negedge clk);
      idle_inputs();
      #3;
      rst = 1'b1;
      #1;
      check_reset_state("mid_rst");
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_rst.in_ready", 64'(in_ready), 64'd1);

      // Randomized traffic honouring the hold-while-stalled rule
      hold = 1'b0; hd = '0; hs = '0; ha = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         logic        v, f, a;
         logic [31:0] d;
         logic [2:0]  s;
         logic [7:0]  ack;
         f   = ($urandom_range(0, 15) == 0);
         ack = 8'($urandom & $urandom);
         if (hold) begin
            v = 1'b1; d = hd; s = hs; a = ha;
         end else begin
            v = $urandom_range(0, 3) != 0;
            d = $urandom;
            s = 3'($urandom_range(0, 7));
            a = $urandom_range(0, 1) == 1;
         end
         cycle(v, d, s, a, f, ack, $sformatf("rnd%0d", k), rdy);
         hold = v && !rdy;
         hd = d; hs = s; ha = a;
      end

      @(negedge clk);
      idle_inputs();
      for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
      if (sb_q.size() > 0) check("drain.queue_empty", 64'(sb_q.size()), 64'd0);
      #1;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
